// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and optional skid entry.
// SKID=1 registers every output; SKID=0 keeps a single entry with comb ready.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W     = 32,
  parameter bit                SKID       = 1'b1,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        count_q, count_d;
  logic              acc, pop;

  assign out_valid = out_valid_q;
  assign out_data  = m_q;
  assign count     = count_q;
  assign in_ready  = SKID ? in_ready_q
                          : (out_ready | ~out_valid_q);

  assign acc = in_valid & in_ready;
  assign pop = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = HALF;
          m_d     = in_data;
        end
      end
      HALF: begin
        if (acc && pop) begin
          m_d = in_data;
        end else if (acc && SKID) begin
          state_d = FULL;
          s_d     = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = HALF;
          m_d     = s_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Bubble insertion: drop the beat, keep stale data.
    if (flush) begin
      state_d = EMPTY;
      m_d     = m_q;
      s_d     = s_q;
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
    count_d     = state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      m_q         <= RESET_DATA;
      s_q         <= RESET_DATA;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: SKID=1 and SKID=0 instances on shared stimulus,
// each checked against a queue model of a bounded FIFO stage.
module tb_pipe_skid_reg;

  localparam logic [31:0] RD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        ir1, ov1, ir0, ov0;
  logic [31:0] od1, od0;
  logic [1:0]  cnt1, cnt0;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .DATA_W(32), .SKID(1'b1), .RESET_DATA(RD)
  ) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1),
    .count(cnt1)
  );

  pipe_skid_reg #(
    .DATA_W(32), .SKID(1'b0), .RESET_DATA(RD)
  ) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0),
    .count(cnt0)
  );

  int ncmp = 0;
  int nbad = 0;
  bit known = 1'b0;
  bit fresh1, fresh0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check against model, advance model, wait edge.
  task automatic cyc(input bit r, input bit f, input bit iv,
                     input logic [31:0] d, input bit ordy);
    bit rdy1, rdy0, acc1, acc0, pop1, pop0;
    @(negedge clk);
    reset = r; flush = f; in_valid = iv;
    in_data = d; out_ready = ordy;
    #1;
    rdy1 = (q1.size() < 2);
    rdy0 = ordy || (q0.size() == 0);
    if (known) begin
      chk("s1_in_ready", 32'(ir1), 32'(rdy1));
      chk("s1_out_valid", 32'(ov1), 32'(q1.size() != 0));
      chk("s1_count", 32'(cnt1), 32'(q1.size()));
      if (q1.size() != 0) chk("s1_out_data", od1, q1[0]);
      else if (fresh1) chk("s1_reset_data", od1, RD);
      chk("s0_in_ready", 32'(ir0), 32'(rdy0));
      chk("s0_out_valid", 32'(ov0), 32'(q0.size() != 0));
      chk("s0_count", 32'(cnt0), 32'(q0.size()));
      if (q0.size() != 0) chk("s0_out_data", od0, q0[0]);
      else if (fresh0) chk("s0_reset_data", od0, RD);
    end
    acc1 = iv && rdy1;
    acc0 = iv && rdy0;
    pop1 = (q1.size() != 0) && ordy;
    pop0 = (q0.size() != 0) && ordy;
    if (r) begin
      q1.delete(); q0.delete();
      fresh1 = 1'b1; fresh0 = 1'b1;
      known = 1'b1;
    end else if (f) begin
      q1.delete(); q0.delete();
    end else begin
      if (pop1) void'(q1.pop_front());
      if (pop0) void'(q0.pop_front());
      if (acc1) begin q1.push_back(d); fresh1 = 1'b0; end
      if (acc0) begin q0.push_back(d); fresh0 = 1'b0; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_ov", 32'(ov1), 32'd0);
    chk("rst_od", od1, RD);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    chk("rst_ir", 32'(ir1), 32'd1);

    // 1: back-to-back stream
    cyc(0, 0, 1, 32'h1000, 1);
    chk("t1_ov", 32'(ov1), 32'd1);
    chk("t1_d0", od1, 32'h1000);
    cyc(0, 0, 1, 32'h1004, 1);
    chk("t1_d1", od1, 32'h1004);
    chk("t1_cnt", 32'(cnt1), 32'd1);
    cyc(0, 0, 1, 32'h1008, 1);
    chk("t1_d2", od1, 32'h1008);
    cyc(0, 0, 0, 32'h0, 1);
    chk("t1_empty", 32'(ov1), 32'd0);

    // 2: skid fill and drain
    cyc(0, 0, 1, 32'hA, 0);
    cyc(0, 0, 1, 32'hB, 0);
    chk("t2_cnt", 32'(cnt1), 32'd2);
    chk("t2_ir", 32'(ir1), 32'd0);
    chk("t2_hold", od1, 32'hA);
    cyc(0, 0, 1, 32'hE, 0);
    chk("t2_stall", od1, 32'hA);
    cyc(0, 0, 0, 32'h0, 1);
    chk("t2_b", od1, 32'hB);
    chk("t2_ir1", 32'(ir1), 32'd1);
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);

    // 3: SKID=0 comb ready (checked by the model each cycle)
    cyc(0, 0, 1, 32'h11, 0);
    cyc(0, 0, 1, 32'h22, 0);
    cyc(0, 0, 1, 32'h22, 1);
    chk("t3_replace", od0, 32'h22);
    cyc(0, 0, 0, 32'h0, 1);

    // 4: flush while full
    cyc(0, 0, 1, 32'hA, 0);
    cyc(0, 0, 1, 32'hB, 0);
    cyc(0, 1, 1, 32'hC, 0);
    chk("t4_ov", 32'(ov1), 32'd0);
    chk("t4_cnt", 32'(cnt1), 32'd0);
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);

    // 5: reset while full
    cyc(0, 0, 1, 32'hA, 0);
    cyc(0, 0, 1, 32'hB, 0);
    cyc(1, 0, 1, 32'h5, 0);
    chk("t5_ov", 32'(ov1), 32'd0);
    chk("t5_od", od1, RD);
    chk("t5_cnt", 32'(cnt1), 32'd0);
    chk("t5_ir", 32'(ir1), 32'd1);
    cyc(0, 0, 1, 32'hD, 0);
    chk("t5_d", od1, 32'hD);
    chk("t5_dv", 32'(ov1), 32'd1);

    // 6: random traffic
    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 499) == 0,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) < 7,
          $urandom,
          $urandom_range(0, 9) < 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
